jk_ff_bist: RTL and testbench
=============================

Name: jk_ff_bist

Overview:
Synthesizable built-in self-test engine that drives the J/K inputs of a JK flip-flop under test and checks its Q output against an internal reference model. It is the active counterpart to the flip-flop: it generates stimulus, reads back the response and reports pass/fail. It sits beside the JK_FF instance and replaces hand-written stimulus for on-chip and regression checking.

Parameters:
NUM_VECTORS, 32, number of J/K stimulus vectors applied per run (>=1).
LFSR_SEED, 8'hA5, initial 8-bit LFSR value; a seed of 0 is replaced by 8'h01.
ERR_CNT_W, 8, width of the error counter.

Ports:
clk  in  1  system clock, all state updates on rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request to begin a run; sampled in IDLE and DONE only.
j_out  out  1  J drive to the DUT, registered.
k_out  out  1  K drive to the DUT, registered.
dut_rst_n  out  1  active-low reset drive to the DUT, registered.
q_in  in  1  Q from the DUT.
busy  out  1  high in INIT, RUN and DRAIN.
done  out  1  high in DONE.
pass  out  1  valid when done=1; high iff err_count==0.
err_count  out  ERR_CNT_W  number of mismatches this run, saturating.
first_err_idx  out  $clog2(NUM_VECTORS+1)  compare index of the first mismatch; valid when err_count!=0.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, j_out=0, k_out=0, dut_rst_n=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, q_model=0, LFSR=seed, vector counter=0. Reset mid-run aborts immediately with no partial result retained.
- States: IDLE -> INIT on start. INIT lasts exactly 2 cycles -> RUN. RUN lasts NUM_VECTORS cycles -> DRAIN. DRAIN lasts 1 cycle -> DONE. DONE -> INIT on start, otherwise it holds.
- Entering INIT from IDLE or DONE: clear err_count, first_err_idx and done; reload LFSR=seed; q_model=0; dut_rst_n=0; j_out=k_out=0.
- dut_rst_n=0 in IDLE and INIT, and 1 in RUN, DRAIN and DONE.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. It advances once per RUN cycle. On the edge entering RUN cycle i, j_out=lfsr[0] and k_out=lfsr[1] for vector i.
- j_out and k_out return to 0 on entering DRAIN and stay 0 until the next RUN.
- Reference model: on every edge ending a RUN cycle, q_model follows JK semantics using the current j_out/k_out: 00 hold, 01 clear, 10 set, 11 toggle. q_model does not change in DRAIN or DONE.
- Compare: on the edge ending each RUN cycle and the DRAIN cycle, q_in is compared to q_model (pre-update values).
  - Compare index c = 0..NUM_VECTORS, for NUM_VECTORS+1 compares in total.
  - c=0 checks the post-reset value 0.
  - Compare c checks the result of vector c-1.
- On mismatch: err_count is incremented, saturating at 2^ERR_CNT_W-1. If err_count was 0, first_err_idx=c.
- Entering DONE: done=1 and pass=(err_count==0, including the DRAIN compare). Results hold until the next start or reset.
- start is ignored while busy=1. A start in the same cycle DONE is entered is ignored.
- Run length: start sampled at edge 0 gives busy=1 after edge 0 and done=1 after edge 3+NUM_VECTORS.

Test Plan:
- Reset check: hold rst=0, toggle clk and start -> all outputs at reset values, dut_rst_n=0, busy=0.
- Correct DUT: connect a golden JK_FF and pulse start -> busy=1 for 3+32 cycles, then done=1, pass=1, err_count=0; j_out/k_out equal the LFSR bits 0/1 from seed 8'hA5.
- Inverted Q: DUT output is ~Q and resets to 1 -> err_count=33, first_err_idx=0, pass=0.
- Stuck-at-0 Q: err_count equals the number of compares where the model value is 1; first_err_idx equals the first compare after the first set or toggle-to-1; pass=0. The bench computes the expected values from its own model.
- Start handling: pulse start during RUN -> ignored and the run completes normally. Pulse start in DONE -> err_count and first_err_idx clear, and the second run reproduces identical j_out/k_out sequence and results.
- Mid-run reset: drive rst=0 at RUN cycle 10 -> outputs return immediately to reset values. After release, the block stays in IDLE until start.

Source files
------------

// File: rtl/jk_ff_bist.sv
// Built-in self-test engine for a JK flip-flop: drives LFSR-derived J/K vectors,
// tracks the expected Q with a reference model and counts mismatches on q_in.
module jk_ff_bist #(
  parameter int          NUM_VECTORS = 32,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5,
  parameter int          ERR_CNT_W   = 8,
  localparam int         IDX_W       = $clog2(NUM_VECTORS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 j_out,
  output logic                 k_out,
  output logic                 dut_rst_n,
  input  logic                 q_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [IDX_W-1:0]     first_err_idx
);

  localparam logic [7:0]       SEED      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [IDX_W-1:0] INIT_LAST = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_VEC  = IDX_W'(NUM_VECTORS - 1);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               state, state_nx;
  logic [7:0]           lfsr;
  logic [IDX_W-1:0]     vec_cnt;
  logic                 q_model;
  logic                 start_run;
  logic                 mismatch;
  logic [ERR_CNT_W-1:0] err_nx;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    case ({j, k})
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return ~q;
      default: return q;
    endcase
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_INIT;
      S_INIT:  if (vec_cnt == INIT_LAST) state_nx = S_RUN;
      S_RUN:   if (vec_cnt == LAST_VEC) state_nx = S_DRAIN;
      S_DRAIN: state_nx = S_DONE;
      S_DONE:  if (start) state_nx = S_INIT;
      default: state_nx = S_IDLE;
    endcase
    start_run = (state == S_IDLE || state == S_DONE) && start;
    // q_in is compared against the model value before this edge's update
    mismatch  = (state == S_RUN || state == S_DRAIN) && (q_in != q_model);
    err_nx    = mismatch ? sat_inc(err_count) : err_count;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      j_out         <= 1'b0;
      k_out         <= 1'b0;
      dut_rst_n     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      q_model       <= 1'b0;
      lfsr          <= SEED;
      vec_cnt       <= '0;
    end else begin
      busy      <= (state_nx == S_INIT) || (state_nx == S_RUN) || (state_nx == S_DRAIN);
      done      <= (state_nx == S_DONE);
      dut_rst_n <= (state_nx == S_RUN) || (state_nx == S_DRAIN) || (state_nx == S_DONE);
      if (start_run) begin
        j_out         <= 1'b0;
        k_out         <= 1'b0;
        pass          <= 1'b0;
        err_count     <= '0;
        first_err_idx <= '0;
        q_model       <= 1'b0;
        lfsr          <= SEED;
        vec_cnt       <= '0;
      end else begin
        case (state)
          S_INIT: begin
            if (state_nx == S_RUN) begin
              vec_cnt <= '0;
              j_out   <= lfsr[0];
              k_out   <= lfsr[1];
              lfsr    <= lfsr_step(lfsr);
            end else begin
              vec_cnt <= vec_cnt + 1'b1;
            end
          end
          S_RUN: begin
            // vec_cnt doubles as the compare index; it reaches NUM_VECTORS for DRAIN
            vec_cnt   <= vec_cnt + 1'b1;
            q_model   <= jk_next(q_model, j_out, k_out);
            err_count <= err_nx;
            if (mismatch && err_count == '0) first_err_idx <= vec_cnt;
            if (state_nx == S_RUN) begin
              j_out <= lfsr[0];
              k_out <= lfsr[1];
              lfsr  <= lfsr_step(lfsr);
            end else begin
              j_out <= 1'b0;
              k_out <= 1'b0;
            end
          end
          S_DRAIN: begin
            err_count <= err_nx;
            if (mismatch && err_count == '0) first_err_idx <= vec_cnt;
            pass      <= (err_nx == '0);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jk_ff_bist.sv
// Directed bench for jk_ff_bist: a JK flip-flop with selectable faults sits on q_in,
// expected vectors and error counts come from a bench-side LFSR/JK model.
module tb_jk_ff_bist;

  localparam int NV = 32;
  localparam int IW = $clog2(NV + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          j_out, k_out, dut_rst_n, q_in, busy, done, pass;
  logic [7:0]    err_count;
  logic [IW-1:0] first_err_idx;

  int   mode = 0;  // 0 golden, 1 inverted Q, 2 stuck-at-0
  logic q_ff;

  int n_pass  = 0;
  int n_total = 0;

  logic [1:0] exp_jk [NV];
  int         exp_stuck_err;
  int         exp_stuck_first;

  logic [1:0] obs_jk [NV];
  int         obs_busy;
  bit         obs_timeout;
  logic [7:0]    obs_err0;
  logic [IW-1:0] obs_fidx0;
  logic          obs_done0;

  always #5 clk = ~clk;

  jk_ff_bist #(.NUM_VECTORS(NV), .LFSR_SEED(8'hA5), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .j_out(j_out), .k_out(k_out),
    .dut_rst_n(dut_rst_n), .q_in(q_in), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx)
  );

  always_ff @(posedge clk or negedge dut_rst_n) begin
    if (!dut_rst_n) q_ff <= 1'b0;
    else case ({j_out, k_out})
      2'b01:   q_ff <= 1'b0;
      2'b10:   q_ff <= 1'b1;
      2'b11:   q_ff <= ~q_ff;
      default: q_ff <= q_ff;
    endcase
  end

  assign q_in = (mode == 1) ? ~q_ff : (mode == 2) ? 1'b0 : q_ff;

  task automatic build_expected();
    logic [7:0] l;
    logic       q;
    l = 8'hA5;
    q = 1'b0;
    exp_stuck_err   = 0;
    exp_stuck_first = -1;
    for (int i = 0; i <= NV; i++) begin
      if (q == 1'b1) begin
        exp_stuck_err++;
        if (exp_stuck_first < 0) exp_stuck_first = i;
      end
      if (i < NV) begin
        exp_jk[i] = {l[1], l[0]};
        case ({l[0], l[1]})
          2'b01: q = 1'b0;
          2'b10: q = 1'b1;
          2'b11: q = ~q;
          default: ;
        endcase
        l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      end
    end
  endtask

  // Pulses start, then records busy cycles and the RUN-cycle J/K drive until done.
  task automatic run_capture(input int mid_start);
    int idx;
    int cyc;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    obs_err0  = err_count;
    obs_fidx0 = first_err_idx;
    obs_done0 = done;
    obs_busy  = 0;
    idx = 0;
    cyc = 0;
    while (!done && cyc < 200) begin
      start = 1'b0;
      if (busy) obs_busy++;
      if (busy && dut_rst_n && idx < NV) begin
        obs_jk[idx] = {k_out, j_out};
        if (idx == mid_start) start = 1'b1;
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    obs_timeout = !done;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk) start = ~start;
    end
    start = 1'b0;
    @(negedge clk);
    n_total++;
    if ({busy, done, pass, j_out, k_out, dut_rst_n, err_count, first_err_idx} !== '0)
      $display("FAIL reset_outputs got busy=%b done=%b pass=%b j=%b k=%b drn=%b err=%0d fidx=%0d exp all 0",
               busy, done, pass, j_out, k_out, dut_rst_n, err_count, first_err_idx);
    else n_pass++;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({busy, done, dut_rst_n} !== 3'b000)
      $display("FAIL idle_after_reset got busy=%b done=%b drn=%b exp 000", busy, done, dut_rst_n);
    else n_pass++;
  endtask

  task automatic test_golden();
    int bad;
    mode = 0;
    run_capture(-1);
    n_total++;
    if (obs_timeout) $display("FAIL golden_timeout got done=%b exp 1", done);
    else n_pass++;
    n_total++;
    if (obs_busy !== NV + 3) $display("FAIL golden_busy_cycles got %0d exp %0d", obs_busy, NV + 3);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < NV; i++) if (obs_jk[i] !== exp_jk[i]) begin
      bad++;
      $display("FAIL golden_jk[%0d] got kj=%b exp kj=%b", i, obs_jk[i], exp_jk[i]);
    end
    n_total++;
    if (bad != 0) $display("FAIL golden_jk_seq got %0d bad vectors exp 0", bad);
    else n_pass++;
    n_total++;
    if ({done, pass, err_count, dut_rst_n, j_out, k_out} !== {1'b1, 1'b1, 8'd0, 1'b1, 2'b00})
      $display("FAIL golden_result got done=%b pass=%b err=%0d drn=%b j=%b k=%b exp 1 1 0 1 0 0",
               done, pass, err_count, dut_rst_n, j_out, k_out);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_total++;
    if ({done, pass, busy} !== 3'b110) $display("FAIL golden_hold got done=%b pass=%b busy=%b exp 110", done, pass, busy);
    else n_pass++;
  endtask

  task automatic test_inverted();
    mode = 1;
    run_capture(-1);
    n_total++;
    if (obs_timeout || err_count !== 8'd33) $display("FAIL inv_err got %0d exp 33", err_count);
    else n_pass++;
    n_total++;
    if (first_err_idx !== '0) $display("FAIL inv_first got %0d exp 0", first_err_idx);
    else n_pass++;
    n_total++;
    if (pass !== 1'b0) $display("FAIL inv_pass got %b exp 0", pass);
    else n_pass++;
  endtask

  task automatic test_stuck0();
    mode = 2;
    run_capture(-1);
    n_total++;
    if (obs_timeout || err_count !== 8'(exp_stuck_err)) $display("FAIL stuck_err got %0d exp %0d", err_count, exp_stuck_err);
    else n_pass++;
    n_total++;
    if (first_err_idx !== IW'(exp_stuck_first)) $display("FAIL stuck_first got %0d exp %0d", first_err_idx, exp_stuck_first);
    else n_pass++;
    n_total++;
    if (pass !== 1'b0) $display("FAIL stuck_pass got %b exp 0", pass);
    else n_pass++;
  endtask

  task automatic test_done_restart();
    int bad;
    mode = 2;
    run_capture(-1);
    n_total++;
    if ({obs_err0, obs_fidx0, obs_done0} !== '0)
      $display("FAIL restart_clear got err=%0d fidx=%0d done=%b exp 0 0 0", obs_err0, obs_fidx0, obs_done0);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < NV; i++) if (obs_jk[i] !== exp_jk[i]) bad++;
    n_total++;
    if (bad != 0) $display("FAIL restart_jk_seq got %0d bad vectors exp 0", bad);
    else n_pass++;
    n_total++;
    if (obs_timeout || err_count !== 8'(exp_stuck_err) || first_err_idx !== IW'(exp_stuck_first))
      $display("FAIL restart_result got err=%0d fidx=%0d exp %0d %0d", err_count, first_err_idx, exp_stuck_err, exp_stuck_first);
    else n_pass++;
  endtask

  task automatic test_start_during_run();
    mode = 0;
    run_capture(5);
    n_total++;
    if (obs_busy !== NV + 3) $display("FAIL midstart_busy got %0d exp %0d", obs_busy, NV + 3);
    else n_pass++;
    n_total++;
    if (obs_timeout || {pass, err_count} !== {1'b1, 8'd0}) $display("FAIL midstart_result got pass=%b err=%0d exp 1 0", pass, err_count);
    else n_pass++;
  endtask

  task automatic test_midrun_reset();
    mode = 1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (12) @(negedge clk);
    n_total++;
    if ({busy, dut_rst_n, err_count} !== {1'b1, 1'b1, 8'd10})
      $display("FAIL midrst_before got busy=%b drn=%b err=%0d exp 1 1 10", busy, dut_rst_n, err_count);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if ({busy, done, pass, j_out, k_out, dut_rst_n, err_count, first_err_idx} !== '0)
      $display("FAIL midrst_async got busy=%b done=%b pass=%b j=%b k=%b drn=%b err=%0d fidx=%0d exp all 0",
               busy, done, pass, j_out, k_out, dut_rst_n, err_count, first_err_idx);
    else n_pass++;
    @(negedge clk) rst = 1'b1;
    repeat (4) @(negedge clk);
    n_total++;
    if ({busy, done, dut_rst_n, err_count} !== '0)
      $display("FAIL midrst_idle got busy=%b done=%b drn=%b err=%0d exp 0", busy, done, dut_rst_n, err_count);
    else n_pass++;
    mode = 0;
    run_capture(-1);
    n_total++;
    if (obs_timeout || {pass, err_count} !== {1'b1, 8'd0}) $display("FAIL midrst_rerun got pass=%b err=%0d exp 1 0", pass, err_count);
    else n_pass++;
  endtask

  initial begin
    build_expected();
    test_reset();
    test_golden();
    test_inverted();
    test_stuck0();
    test_done_restart();
    test_start_during_run();
    test_midrun_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
